// File: rtl/div_result_bcd_if.sv
// Handshake bundle between the divider, the binary-to-BCD converter and the readout logic.
// The master side is the upstream/consumer pair, and the slave side is the converter.
interface div_result_bcd_if #(
    parameter int SIZE   = 4,
    parameter int DIGITS = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SIZE-1:0]       quo;
    logic [SIZE-1:0]       rem;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   quo_bcd;
    logic [4*DIGITS-1:0]   rem_bcd;
    logic                  busy;

    modport master (
        output in_valid, quo, rem, out_ready,
        input  in_ready, out_valid, quo_bcd, rem_bcd, busy
    );

    modport slave (
        input  in_valid, quo, rem, out_ready,
        output in_ready, out_valid, quo_bcd, rem_bcd, busy
    );
endinterface

// File: rtl/div_result_bcd.sv
// Sequential double-dabble converter for the divider's quotient/remainder pair.
// It converts one bit per clock and holds the packed BCD result until the consumer takes it.
module div_result_bcd #(
    parameter int SIZE   = 4,
    parameter int DIGITS = 2,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    div_result_bcd_if.slave    bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [SIZE-1:0]    r_quo_bin;
    logic [SIZE-1:0]    r_rem_bin;
    logic [ACC_W-1:0]   r_quo_acc;
    logic [ACC_W-1:0]   r_rem_acc;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [ACC_W-1:0]   w_quo_adj;
    logic [ACC_W-1:0]   w_rem_adj;
    logic [ACC_W-1:0]   w_quo_acc_sh;
    logic [ACC_W-1:0]   w_rem_acc_sh;
    logic [SIZE-1:0]    w_quo_bin_sh;
    logic [SIZE-1:0]    w_rem_bin_sh;

    // Add 3 to every digit of 5 or more so that the following shift carries into the next decade.
    function automatic logic [ACC_W-1:0] dabble_adj(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] res;
        logic [3:0]       dig;
        res = acc;
        for (int i = 0; i < DIGITS; i++) begin
            dig = acc[4*i +: 4];
            if (dig >= 4'd5) begin
                res[4*i +: 4] = dig + 4'd3;
            end else begin
                res[4*i +: 4] = dig;
            end
        end
        return res;
    endfunction

    // Combined adjust-then-shift step applied to both values.
    always_comb begin
        w_quo_adj    = dabble_adj(r_quo_acc);
        w_rem_adj    = dabble_adj(r_rem_acc);
        w_quo_acc_sh = {w_quo_adj[ACC_W-2:0], r_quo_bin[SIZE-1]};
        w_rem_acc_sh = {w_rem_adj[ACC_W-2:0], r_rem_bin[SIZE-1]};
        w_quo_bin_sh = {r_quo_bin[SIZE-2:0], 1'b0};
        w_rem_bin_sh = {r_rem_bin[SIZE-2:0], 1'b0};
    end

    // Next-state logic for the IDLE/CONV/DONE sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = S_CONV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONV: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CONV;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, handshake flags and datapath registers.
    // The flags are derived from the next state, so the outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_quo_bin   <= {SIZE{1'b0}};
            r_rem_bin   <= {SIZE{1'b0}};
            r_quo_acc   <= {ACC_W{1'b0}};
            r_rem_acc   <= {ACC_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt == S_CONV);
            r_out_valid <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_quo_bin <= bus.quo;
                        r_rem_bin <= bus.rem;
                        r_quo_acc <= {ACC_W{1'b0}};
                        r_rem_acc <= {ACC_W{1'b0}};
                        r_cnt     <= {CNT_W{1'b0}};
                    end
                end
                S_CONV: begin
                    r_quo_acc <= w_quo_acc_sh;
                    r_rem_acc <= w_rem_acc_sh;
                    r_quo_bin <= w_quo_bin_sh;
                    r_rem_bin <= w_rem_bin_sh;
                    r_cnt     <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.quo_bcd   = r_quo_acc;
    assign bus.rem_bcd   = r_rem_acc;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed scoreboard bench for div_result_bcd.
// Expected BCD pairs are queued at accept time and compared when the result is presented.
module tb_div_result_bcd;
    localparam int SIZE   = 4;
    localparam int DIGITS = 2;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [15:0] exp_q[$];

    div_result_bcd_if #(.SIZE(SIZE), .DIGITS(DIGITS)) bus ();

    div_result_bcd #(.SIZE(SIZE), .DIGITS(DIGITS), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'((v / 10) % 10);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int q, input int r);
        bus.quo      = 4'(q);
        bus.rem      = 4'(r);
        bus.in_valid = 1'b1;
        check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        exp_q.push_back({to_bcd(q), to_bcd(r)});
        tick();
        bus.in_valid = 1'b0;
        check("busy_conv", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(SIZE));
        check("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
    endtask

    task automatic finish_txn();
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            e = 16'hxxxx;
        end else begin
            e = exp_q.pop_front();
        end
        check("quo_bcd", {24'd0, bus.quo_bcd}, {24'd0, e[15:8]});
        check("rem_bcd", {24'd0, bus.rem_bcd}, {24'd0, e[7:0]});
        bus.out_ready = 1'b1;
        tick();
        check("out_valid_clr", {31'd0, bus.out_valid}, 32'd0);
        check("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic run_txn(input int q, input int r);
        bus.out_ready = 1'b1;
        start(q, r);
        wait_done();
        finish_txn();
    endtask

    initial begin
        logic [15:0] held;
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.quo      = 4'd0;
        bus.rem      = 4'd0;
        bus.out_ready = 1'b0;

        // Reset and idle
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_quo_bcd", {24'd0, bus.quo_bcd}, 32'h00);
        check("rst_rem_bcd", {24'd0, bus.rem_bcd}, 32'h00);
        tick();

        // Basic and extreme pairs
        run_txn(13, 2);
        run_txn(15, 0);
        run_txn(0, 9);
        run_txn(0, 0);

        // Backpressure: hold the result while inputs toggle
        bus.out_ready = 1'b0;
        start(6, 11);
        wait_done();
        held = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.quo      = 4'($urandom_range(15, 0));
            bus.rem      = 4'($urandom_range(15, 0));
            tick();
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_quo_bcd", {24'd0, bus.quo_bcd}, {24'd0, held[15:8]});
            check("bp_rem_bcd", {24'd0, bus.rem_bcd}, {24'd0, held[7:0]});
        end
        bus.in_valid = 1'b0;
        finish_txn();
        tick();
        check("bp_no_accept_busy", {31'd0, bus.busy}, 32'd0);
        check("bp_no_accept_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Input isolation: operands change during conversion
        bus.out_ready = 1'b1;
        start(7, 1);
        bus.quo = 4'd12;
        bus.rem = 4'd5;
        wait_done();
        finish_txn();

        // Reset on the second conversion cycle aborts cleanly
        bus.quo      = 4'd9;
        bus.rem      = 4'd9;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_quo_bcd", {24'd0, bus.quo_bcd}, 32'h00);
        check("abort_rem_bcd", {24'd0, bus.rem_bcd}, 32'h00);
        run_txn(10, 3);

        // Full sweep against the decimal model
        for (int q = 0; q < 16; q++) begin
            for (int r = 0; r < 16; r++) begin
                run_txn(q, r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
